// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths and transaction arbiter state encoding
// Purpose: common definitions for the i2c_txn_arbiter slice.
//   I2C_ADDR_W  7-bit slave address width
//   I2C_DATA_W  8-bit data byte width
//   arb_state_t arbiter sequencing states
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINISH = 3'd3,
    ST_GAP    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
// Purpose: selects the first set request at or after ptr, wrapping.
// Ports:
//   req    in   NREQ   request vector
//   ptr    in   IDX_W  index searched first
//   gnt    out  NREQ   one-hot winner (all zero when no request)
//   idx    out  IDX_W  winner index
//   valid  out  1      any request present
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sequencer sharing one i2c_master
// Purpose: grants one requester at a time, drives the master, waits for its
//   ready handshake, returns read data with a done pulse; a watchdog aborts
//   hung transactions with an err pulse. All outputs are registered.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req/req_addr/req_wdata/req_rd   per-requester request, address, write byte, read flag
//   gnt/done/err           per-requester one-hot grant, completion and timeout pulses
//   rdata                  read byte, valid with done, held until next read done
//   busy                   high whenever not idle
//   m_addr/m_data_in/m_rd_wr/m_enable   to i2c_master
//   m_ready/m_data_out     from i2c_master
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 4096,
  parameter int GAP_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*I2C_ADDR_W-1:0]   req_addr,
  input  logic [NREQ*I2C_DATA_W-1:0]   req_wdata,
  input  logic [NREQ-1:0]              req_rd,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic [NREQ-1:0]              err,
  output logic [I2C_DATA_W-1:0]        rdata,
  output logic                         busy,
  output logic [I2C_ADDR_W-1:0]        m_addr,
  output logic [I2C_DATA_W-1:0]        m_data_in,
  output logic                         m_rd_wr,
  output logic                         m_enable,
  input  logic                         m_ready,
  input  logic [I2C_DATA_W-1:0]        m_data_out
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, idx, win_idx, ptr_adv;
  logic [NREQ-1:0]  win_gnt, owner;
  logic             win_valid;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             start, complete, timeout;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign owner   = NREQ'(1) << idx;
  assign ptr_adv = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Completion in RUN takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid && m_ready) begin
          start     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wd_cnt == WD_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_GAP;
        end else if (!m_ready) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (m_ready) begin
          complete  = 1'b1;
          state_nxt = ST_FINISH;
        end else if (wd_cnt == WD_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_FINISH: state_nxt = ST_GAP;
      ST_GAP:    if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      idx       <= '0;
      wd_cnt    <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rd_wr   <= 1'b0;
      m_enable  <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      busy <= (state_nxt != ST_IDLE);

      if (start) begin
        idx       <= win_idx;
        gnt       <= win_gnt;
        m_addr    <= req_addr[win_idx*I2C_ADDR_W +: I2C_ADDR_W];
        m_data_in <= req_wdata[win_idx*I2C_DATA_W +: I2C_DATA_W];
        m_rd_wr   <= req_rd[win_idx];
        m_enable  <= 1'b1;
        // The grant edge counts as the first watchdog cycle, so err lands
        // TIMEOUT-1 cycles after gnt rises.
        wd_cnt    <= WD_W'(1);
      end

      if (state == ST_ISSUE || state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;

      // Writes keep enable high so the master can leave its slave-ACK state.
      if (state == ST_ISSUE && state_nxt == ST_RUN) m_enable <= ~m_rd_wr;

      if (complete) begin
        m_enable <= 1'b0;
        done     <= owner;
        if (m_rd_wr) rdata <= m_data_out;
      end

      if (timeout) begin
        m_enable <= 1'b0;
        err      <= owner;
        gnt      <= '0;
        ptr      <= ptr_adv;
      end

      if (state == ST_FINISH) begin
        gnt <= '0;
        ptr <= ptr_adv;
      end

      if (state_nxt == ST_GAP && state != ST_GAP) gap_cnt <= '0;
      else if (state == ST_GAP)                   gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - scoreboard bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

  localparam int NREQ       = 4;
  localparam int TIMEOUT    = 256;
  localparam int GAP_CYCLES = 8;
  localparam logic [6:0] NACK_ADDR  = 7'h11;
  localparam logic [6:0] STUCK_ADDR = 7'h7F;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   req_rd;
  logic [NREQ-1:0]   gnt, done, err;
  logic [7:0]        rdata;
  logic              busy;
  logic [6:0]        m_addr;
  logic [7:0]        m_data_in;
  logic              m_rd_wr, m_enable, m_ready;
  logic [7:0]        m_data_out;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd_wr(m_rd_wr), .m_enable(m_enable),
    .m_ready(m_ready), .m_data_out(m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rd;
    logic       exp_err;
    logic       chk_rdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb_q[$];
  logic       mon_active;
  int         model_ptr;
  logic [7:0] ref_mem [128];
  logic [7:0] bus_mem [128];
  logic [7:0] hold_val;
  logic       hold_known;

  // Reference: all batch requests are pending together, so service order is
  // one pass of the rotation starting at the pointer left by the last owner.
  task automatic model_batch(input logic [NREQ-1:0] mask, input logic [NREQ*7-1:0] addrs,
                             input logic [NREQ*8-1:0] wdatas, input logic [NREQ-1:0] rds);
    int base;
    base = model_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      exp_t e;
      j = (base + k) % NREQ;
      if (mask[j]) begin
        e.idx     = j;
        e.addr    = addrs[j*7 +: 7];
        e.wdata   = wdatas[j*8 +: 8];
        e.rd      = rds[j];
        e.exp_err = (e.addr == STUCK_ADDR);
        e.chk_rdata = 1'b0;
        e.rdata     = 8'h00;
        if (e.exp_err) begin
          e.chk_rdata = 1'b0;
        end else if (e.addr == NACK_ADDR) begin
          e.chk_rdata = !e.rd && hold_known;
          e.rdata     = hold_val;
          if (e.rd) hold_known = 1'b0;
        end else if (e.rd) begin
          e.chk_rdata = 1'b1;
          e.rdata     = ref_mem[e.addr];
          hold_val    = e.rdata;
          hold_known  = 1'b1;
        end else begin
          e.chk_rdata = hold_known;
          e.rdata     = hold_val;
          ref_mem[e.addr] = e.wdata;
        end
        sb_q.push_back(e);
        model_ptr = (j + 1) % NREQ;
      end
    end
  endtask

  // Bus + slave stand-in: drops ready after seeing enable, stays busy a random
  // time, then returns ready. STUCK_ADDR hangs well past the watchdog.
  initial begin
    int         mstate, mcnt;
    logic       need_low, cur_rd;
    logic [6:0] cur_addr;
    logic [7:0] cur_wdata;
    mstate = 0; mcnt = 0; need_low = 1'b0; cur_rd = 1'b0; cur_addr = '0; cur_wdata = '0;
    m_ready = 1'b1;
    m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        mstate = 0;
        m_ready = 1'b1;
        need_low = 1'b0;
      end else if (mstate == 0) begin
        if (!m_enable) need_low = 1'b0;
        else if (m_ready && !need_low) begin
          cur_addr = m_addr; cur_rd = m_rd_wr; cur_wdata = m_data_in;
          m_ready = 1'b0;
          mstate = 1;
          if (cur_addr == STUCK_ADDR)     mcnt = TIMEOUT + 20;
          else if (cur_addr == NACK_ADDR) mcnt = 3;
          else                            mcnt = $urandom_range(4, 30);
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          if (cur_addr != STUCK_ADDR) begin
            chk("m_enable_in_run", {31'd0, m_enable}, {31'd0, !cur_rd});
            if (cur_addr == NACK_ADDR) m_data_out = 8'($urandom);
            else if (cur_rd)           m_data_out = bus_mem[cur_addr];
            else                       bus_mem[cur_addr] = cur_wdata;
          end
          m_ready  = 1'b1;
          mstate   = 0;
          need_low = (cur_addr != STUCK_ADDR);
        end
      end
    end
  end

  // Monitor: pops the expectation at each grant, checks it on done/err.
  initial begin
    exp_t            cur;
    logic [NREQ-1:0] prev_gnt, prev_done, prev_err;
    logic            prev_ready, have_end;
    int              grant_cyc, end_cyc;
    mon_active = 1'b0;
    prev_gnt = '0; prev_done = '0; prev_err = '0; prev_ready = 1'b1; have_end = 1'b0;
    grant_cyc = 0; end_cyc = 0;
    cur = '{0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mon_active = 1'b0;
        prev_gnt = '0; prev_done = '0; prev_err = '0; prev_ready = 1'b1; have_end = 1'b0;
      end else begin
        chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
        if (done != 0 || err != 0) begin
          chk("end_pulse_single", {28'd0, prev_done | prev_err}, 32'd0);
          if (!mon_active) begin
            chk("unexpected_end", {28'd0, done | err}, 32'd0);
          end else if (cur.exp_err) begin
            chk("err_owner", {28'd0, err}, {28'd0, oh(cur.idx)});
            chk("err_no_done", {28'd0, done}, 32'd0);
            chk("err_latency", cyc - grant_cyc, TIMEOUT - 1);
          end else begin
            chk("done_owner", {28'd0, done}, {28'd0, oh(cur.idx)});
            chk("done_no_err", {28'd0, err}, 32'd0);
            chk("done_after_ready", {31'd0, m_ready && !prev_ready}, 32'd1);
            if (cur.chk_rdata) chk("rdata", {24'd0, rdata}, {24'd0, cur.rdata});
          end
          mon_active = 1'b0;
          end_cyc = cyc;
          have_end = 1'b1;
        end else if (mon_active) begin
          chk("gnt_hold", {28'd0, gnt}, {28'd0, oh(cur.idx)});
        end else if (gnt != 0) begin
          if (prev_gnt != 0) chk("gnt_stale", {28'd0, gnt}, 32'd0);
          else if (sb_q.size() == 0) chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
          else begin
            cur = sb_q.pop_front();
            mon_active = 1'b1;
            grant_cyc = cyc;
            chk("gnt_order", {28'd0, gnt}, {28'd0, oh(cur.idx)});
            chk("m_addr", {25'd0, m_addr}, {25'd0, cur.addr});
            chk("m_rd_wr", {31'd0, m_rd_wr}, {31'd0, cur.rd});
            if (!cur.rd) chk("m_data_in", {24'd0, m_data_in}, {24'd0, cur.wdata});
            chk("m_enable_issue", {31'd0, m_enable}, 32'd1);
            chk("busy_owned", {31'd0, busy}, 32'd1);
            if (have_end) chk("gap_cycles", {31'd0, (cyc - end_cyc) >= GAP_CYCLES}, 32'd1);
          end
        end
        prev_gnt = gnt; prev_done = done; prev_err = err; prev_ready = m_ready;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 3000 && !(busy == 1'b0 && req == 0 && sb_q.size() == 0 && !mon_active)) begin
      @(posedge clk); #3;
      t++;
    end
    if (t >= 3000) chk("idle_timeout", t, 0);
  endtask

  task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ*7-1:0] addrs,
                           input logic [NREQ*8-1:0] wdatas, input logic [NREQ-1:0] rds,
                           input logic drop);
    int t;
    wait_idle();
    model_batch(mask, addrs, wdatas, rds);
    req_addr = addrs; req_wdata = wdatas; req_rd = rds;
    req = mask;
    t = 0;
    while (t < 5000 && req != 0) begin
      @(posedge clk); #3;
      t++;
      req = req & ~(done | err);
      if (gnt != 0) begin
        if (drop) req = req & ~gnt;
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            req_addr[i*7 +: 7]  = 7'($urandom);
            req_wdata[i*8 +: 8] = 8'($urandom);
            req_rd[i]           = 1'($urandom);
          end
        end
      end
    end
    if (t >= 5000) chk("batch_timeout", {28'd0, req}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_err"}, {28'd0, err}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_m_addr"}, {25'd0, m_addr}, 32'd0);
    chk({tag, "_m_data_in"}, {24'd0, m_data_in}, 32'd0);
    chk({tag, "_m_rd_wr"}, {31'd0, m_rd_wr}, 32'd0);
    chk({tag, "_m_enable"}, {31'd0, m_enable}, 32'd0);
  endtask

  initial begin
    logic [NREQ*7-1:0] a;
    logic [NREQ*8-1:0] w;
    logic [NREQ-1:0]   r, mask;
    int                t;
    rst = 1'b1;
    req = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    model_ptr = 0; hold_val = 8'h00; hold_known = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[7'h68] = 8'h3C;
    bus_mem[7'h68] = 8'h3C;

    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst = 1'b0;

    // single write, then single read from requester 2
    run_batch(4'b0001, {7'h0, 7'h0, 7'h0, 7'h50}, {8'h0, 8'h0, 8'h0, 8'hA5}, 4'b0000, 1'b0);
    run_batch(4'b0100, {7'h0, 7'h68, 7'h0, 7'h0}, '0, 4'b0100, 1'b0);
    // all four together, twice, mixed directions
    run_batch(4'b1111, {7'h20, 7'h21, 7'h22, 7'h23}, {8'h11, 8'h22, 8'h33, 8'h44}, 4'b1010, 1'b0);
    run_batch(4'b1111, {7'h23, 7'h22, 7'h21, 7'h20}, {8'h55, 8'h66, 8'h77, 8'h88}, 4'b0101, 1'b1);
    // hung bus on requester 1; requester 2 must follow
    run_batch(4'b0110, {7'h0, 7'h30, STUCK_ADDR, 7'h0}, {8'h0, 8'h9A, 8'h5C, 8'h0}, 4'b0000, 1'b0);
    // NACKed write then a read that must still succeed
    run_batch(4'b0011, {7'h0, 7'h0, 7'h68, NACK_ADDR}, {8'h0, 8'h0, 8'h0, 8'hC3}, 4'b0010, 1'b0);

    // reset while RUN: requester 2 leaves the pointer at 3 first
    run_batch(4'b0100, {7'h0, 7'h24, 7'h0, 7'h0}, {8'h0, 8'h5A, 8'h0, 8'h0}, 4'b0000, 1'b0);
    wait_idle();
    model_batch(4'b0100, {7'h0, 7'h25, 7'h0, 7'h0}, '0, 4'b0100);
    req_addr = {7'h0, 7'h25, 7'h0, 7'h0}; req_rd = 4'b0100; req = 4'b0100;
    t = 0;
    while (t < 200 && !(gnt != 0 && !m_ready)) begin
      @(posedge clk); #3;
      t++;
    end
    chk("reached_run", {31'd0, t < 200}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    req = '0;
    sb_q.delete();
    model_ptr = 0; hold_val = 8'h00; hold_known = 1'b1;
    @(posedge clk); #2;
    check_all_zero("midrst");
    @(posedge clk); #3;
    rst = 1'b0;
    // pointer must restart at 0: requester 1 ahead of 3
    run_batch(4'b1010, {7'h26, 7'h0, 7'h27, 7'h0}, {8'h31, 8'h0, 8'h13, 8'h0}, 4'b1000, 1'b0);

    for (int b = 0; b < 25; b++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0)      a[i*7 +: 7] = STUCK_ADDR;
        else if (sel == 1) a[i*7 +: 7] = NACK_ADDR;
        else               a[i*7 +: 7] = 7'($urandom_range(32'h20, 32'h2F));
        w[i*8 +: 8] = 8'($urandom);
        r[i]        = 1'($urandom);
      end
      run_batch(mask, a, w, r, ($urandom_range(0, 3) == 0));
    end

    wait_idle();
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
